unidec_param: RTL and testbench

UNIDEC_PARAM -- requirements
Module: unidec_param

---
 rtl/unidec_param.sv | 179 +++++++++++++++++
 tb/tb_unidec_param.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidec_param.sv
// unidec_param: stepwise unique-decodability search over a small code table.
// The environment picks a table word and prefix length each RUN cycle; one rule is applied per cycle.
module unidec_param #(
  parameter int CHAR_W    = 3,
  parameter int MAX_LEN   = 5,
  parameter int NUM_WORDS = 8,
  parameter int MAX_STEPS = 255,
  localparam int WORD_W   = CHAR_W*MAX_LEN+1,
  localparam int SEL_W    = $clog2(NUM_WORDS),
  localparam int LEN_W    = $clog2(MAX_LEN),
  localparam int STEP_W   = $clog2(MAX_STEPS+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tbl_we,
  input  logic [SEL_W-1:0]  tbl_addr,
  input  logic [WORD_W-1:0] tbl_data,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  sel_word,
  input  logic [LEN_W-1:0]  sel_len,
  output logic              busy,
  output logic              found,
  output logic              trapped,
  output logic              timeout,
  output logic [STEP_W-1:0] steps,
  output logic [WORD_W-1:0] word
);

  // states: IDLE table writable | RUN one rule per cycle | FOUND ambiguity seen | TRAP dead end or timeout
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOUND, S_TRAP} state_t;

  localparam logic [WORD_W-1:0] ONE       = WORD_W'(1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS-1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              busy_q, busy_d;
  logic              found_q, found_d;
  logic              trapped_q, trapped_d;
  logic              timeout_q, timeout_d;
  logic [WORD_W-1:0] tbl_q [NUM_WORDS];
  logic [WORD_W-1:0] tbl_d [NUM_WORDS];

  logic [WORD_W-1:0] other;
  logic [WORD_W-1:0] stop_k, mask_k;
  logic [WORD_W-1:0] sfx_a, sfx_b;
  logic [LEN_W:0]    p, len_w, len_o;
  logic              hit, rule_a, rule_b;

  // Length is the character count below the highest set (stop) bit.
  function automatic logic [LEN_W:0] word_len(input logic [WORD_W-1:0] w);
    logic [LEN_W:0] n;
    n = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (w[i]) n = (LEN_W+1)'(i / CHAR_W);
    end
    return n;
  endfunction

  always_comb begin
    other  = tbl_q[sel_word];
    p      = {1'b0, sel_len} + (LEN_W+1)'(1);
    len_w  = word_len(word_q);
    len_o  = word_len(other);
    hit    = (steps_q != '0) && (other != '0) && (word_q == other);
    rule_a = 1'b0;
    rule_b = 1'b0;
    stop_k = '0;
    mask_k = '0;
    sfx_a  = '0;
    sfx_b  = '0;
    // Only prefix lengths below MAX_LEN can ever match; larger p falls through to TRAP.
    for (int k = 1; k < MAX_LEN; k++) begin
      if (p == (LEN_W+1)'(k)) begin
        stop_k = ONE << (k*CHAR_W);
        mask_k = stop_k - ONE;
        rule_a = (len_w > (LEN_W+1)'(k)) && (other == (stop_k | (word_q & mask_k)));
        rule_b = (len_o > (LEN_W+1)'(k)) && (word_q == (stop_k | (other & mask_k)));
        sfx_a  = word_q >> (k*CHAR_W);
        sfx_b  = other >> (k*CHAR_W);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    steps_d   = steps_q;
    busy_d    = busy_q;
    found_d   = found_q;
    trapped_d = trapped_q;
    timeout_d = timeout_q;
    tbl_d     = tbl_q;

    if (tbl_we && (state_q == S_IDLE)) tbl_d[tbl_addr] = tbl_data;

    if (abort) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      found_d   = 1'b0;
      trapped_d = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (hit) begin
            state_d = S_FOUND;
            busy_d  = 1'b0;
            found_d = 1'b1;
          end else if (rule_a || rule_b) begin
            if (steps_q == LAST_STEP) begin
              state_d   = S_TRAP;
              busy_d    = 1'b0;
              trapped_d = 1'b1;
              timeout_d = 1'b1;
            end else begin
              steps_d = steps_q + STEP_W'(1);
              word_d  = rule_a ? sfx_a : sfx_b;
            end
          end else begin
            state_d   = S_TRAP;
            busy_d    = 1'b0;
            trapped_d = 1'b1;
            word_d    = '0;
          end
        end
        default: begin
          if (start) begin
            word_d    = tbl_q[sel_word];
            steps_d   = '0;
            found_d   = 1'b0;
            timeout_d = 1'b0;
            if (tbl_q[sel_word] == '0) begin
              state_d   = S_TRAP;
              busy_d    = 1'b0;
              trapped_d = 1'b1;
            end else begin
              state_d   = S_RUN;
              busy_d    = 1'b1;
              trapped_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      steps_q   <= '0;
      busy_q    <= 1'b0;
      found_q   <= 1'b0;
      trapped_q <= 1'b0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) tbl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      steps_q   <= steps_d;
      busy_q    <= busy_d;
      found_q   <= found_d;
      trapped_q <= trapped_d;
      timeout_q <= timeout_d;
      for (int i = 0; i < NUM_WORDS; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign busy    = busy_q;
  assign found   = found_q;
  assign trapped = trapped_q;
  assign timeout = timeout_q;
  assign steps   = steps_q;
  assign word    = word_q;

endmodule

// File: tb/tb_unidec_param.sv
// Bench for unidec_param: directed vector table, hand sequences for reset/abort/timeout,
// and a randomized run against a character-level reference model.
module tb_unidec_param;
  localparam int CW  = 3;
  localparam int ML  = 5;
  localparam int NW  = 8;
  localparam int WW  = CW*ML+1;
  localparam int STW = 8;

  typedef struct packed {
    logic                  valid;
    logic [3:0]            len;
    logic [ML-1:0][CW-1:0] ch;
  } mword_t;

  typedef struct packed {
    logic [2:0]  sw;
    logic [2:0]  sl;
    logic [15:0] w;
    logic        b;
    logic        f;
    logic [7:0]  st;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tbl_we;
  logic [2:0]    tbl_addr;
  logic [WW-1:0] tbl_data;
  logic          start, abort;
  logic [2:0]    sel_word;
  logic [2:0]    sel_len;
  logic          busy, found, trapped, timeout;
  logic [STW-1:0] steps;
  logic [WW-1:0] word;
  logic          busy3, found3, trapped3, timeout3;
  logic [1:0]    steps3;
  logic [WW-1:0] word3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unidec_param u_dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .abort(abort), .sel_word(sel_word), .sel_len(sel_len),
    .busy(busy), .found(found), .trapped(trapped), .timeout(timeout),
    .steps(steps), .word(word)
  );

  unidec_param #(.MAX_STEPS(3)) u_dut3 (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .abort(abort), .sel_word(sel_word), .sel_len(sel_len),
    .busy(busy3), .found(found3), .trapped(trapped3), .timeout(timeout3),
    .steps(steps3), .word(word3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic go(input logic [2:0] s);
    sel_word = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stepsel(input logic [2:0] s, input logic [2:0] l);
    sel_word = s; sel_len = l;
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_demo();
    wr(3'd0, 16'h0008);
    wr(3'd1, 16'h000A);
    wr(3'd2, 16'h0058);
    wr(3'd3, 16'h0248);
    wr(3'd4, 16'h02C1);
    wr(3'd5, 16'h0263);
    wr(3'd6, 16'hC689);
  endtask

  // ---------------- character-level reference model ----------------
  string  ms;
  mword_t mw;
  int     msteps;
  bit     mbusy, mfound, mtrap, mto;
  mword_t mtbl [NW];
  mword_t wr_w;

  function automatic logic [WW-1:0] enc(input mword_t w);
    logic [WW-1:0] r;
    r = '0;
    if (w.valid) begin
      r[int'(w.len)*CW] = 1'b1;
      for (int i = 0; i < ML; i++) if (i < int'(w.len)) r[i*CW +: CW] = w.ch[i];
    end
    return r;
  endfunction

  function automatic mword_t rand_word();
    mword_t w;
    w = '0;
    if ($urandom_range(0, 7) != 0) begin
      w.valid = 1'b1;
      w.len   = 4'($urandom_range(1, 4));
      for (int i = 0; i < ML; i++) if (i < int'(w.len)) w.ch[i] = 3'($urandom_range(0, 1));
    end
    return w;
  endfunction

  function automatic bit prefix_eq(input mword_t a, input mword_t b, input int p);
    bit eq;
    eq = 1'b1;
    for (int i = 0; i < ML; i++) if (i < p && a.ch[i] != b.ch[i]) eq = 1'b0;
    return eq;
  endfunction

  function automatic mword_t suffix(input mword_t w, input int p);
    mword_t r;
    r = '0;
    r.valid = 1'b1;
    r.len   = 4'(int'(w.len) - p);
    for (int i = 0; i < ML; i++) if (i + p < ML && i < int'(r.len)) r.ch[i] = w.ch[i+p];
    return r;
  endfunction

  task automatic model_reset();
    ms = "IDLE"; mw = '0; msteps = 0;
    mbusy = 0; mfound = 0; mtrap = 0; mto = 0;
    for (int i = 0; i < NW; i++) mtbl[i] = '0;
  endtask

  task automatic model_cycle(input int max_steps);
    mword_t other, nw;
    int     p;
    bit     upd;
    bit     was_idle;
    was_idle = (ms == "IDLE");
    other = mtbl[sel_word];
    p = int'(sel_len) + 1;
    nw = '0;
    upd = 1'b0;
    if (abort) begin
      ms = "IDLE"; mbusy = 0; mfound = 0; mtrap = 0; mto = 0;
    end else if (ms != "RUN") begin
      if (start) begin
        msteps = 0; mfound = 0; mto = 0; mw = other;
        if (!other.valid) begin ms = "TRAP"; mtrap = 1; mbusy = 0; end
        else begin ms = "RUN"; mtrap = 0; mbusy = 1; end
      end
    end else if (msteps != 0 && other.valid && mw == other) begin
      ms = "FOUND"; mfound = 1; mbusy = 0;
    end else begin
      if (p < ML && other.valid) begin
        if (int'(mw.len) > p && int'(other.len) == p && prefix_eq(mw, other, p)) begin
          upd = 1'b1; nw = suffix(mw, p);
        end else if (int'(other.len) > p && int'(mw.len) == p && prefix_eq(mw, other, p)) begin
          upd = 1'b1; nw = suffix(other, p);
        end
      end
      if (!upd) begin
        ms = "TRAP"; mtrap = 1; mbusy = 0; mw = '0;
      end else if (msteps + 1 == max_steps) begin
        ms = "TRAP"; mtrap = 1; mto = 1; mbusy = 0;
      end else begin
        msteps++; mw = nw;
      end
    end
    if (was_idle && tbl_we) mtbl[tbl_addr] = wr_w;
  endtask

  vec_t vec [6];

  initial begin
    vec[0] = '{sw: 3'd0, sl: 3'd0, w: 16'h0049, b: 1'b1, f: 1'b0, st: 8'd1};
    vec[1] = '{sw: 3'd6, sl: 3'd1, w: 16'h031A, b: 1'b1, f: 1'b0, st: 8'd2};
    vec[2] = '{sw: 3'd1, sl: 3'd0, w: 16'h0063, b: 1'b1, f: 1'b0, st: 8'd3};
    vec[3] = '{sw: 3'd5, sl: 3'd1, w: 16'h0009, b: 1'b1, f: 1'b0, st: 8'd4};
    vec[4] = '{sw: 3'd4, sl: 3'd0, w: 16'h0058, b: 1'b1, f: 1'b0, st: 8'd5};
    vec[5] = '{sw: 3'd2, sl: 3'd0, w: 16'h0058, b: 1'b0, f: 1'b1, st: 8'd5};

    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    start = 1'b0; abort = 1'b0; sel_word = '0; sel_len = '0;
    tick(); tick();
    check("reset_outputs", {busy, found, trapped, timeout, steps, word}, '0);
    check("reset_outputs_ms3", {busy3, found3, trapped3, timeout3, steps3, word3}, '0);
    rst = 1'b0;
    tick();

    // Full decoding chain ending in an ambiguity.
    load_demo();
    go(3'd3);
    check("start_abb", {busy, found, trapped, steps, word}, {1'b1, 1'b0, 1'b0, 8'd0, 16'h0248});
    for (int i = 0; i < 6; i++) begin
      stepsel(vec[i].sw, vec[i].sl);
      check($sformatf("chain_step%0d", i), {busy, found, trapped, steps, word},
            {vec[i].b, vec[i].f, 1'b0, vec[i].st, vec[i].w});
    end
    stepsel(3'd0, 3'd0);
    check("found_holds", {busy, found, trapped, steps}, {1'b0, 1'b1, 1'b0, 8'd5});

    // Abort wins over start in FOUND.
    abort = 1'b1; start = 1'b1; sel_word = 3'd3;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_beats_start", {busy, found, trapped, timeout}, 4'b0000);

    // a followed by c: neither rule applies.
    go(3'd0);
    check("start_a", {busy, word}, {1'b1, 16'h0008});
    stepsel(3'd1, 3'd0);
    check("a_c_trap", {busy, found, trapped, timeout, word}, {1'b1 ^ 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});

    // Table writes outside IDLE are dropped.
    go(3'd3);
    tbl_we = 1'b1; tbl_addr = 3'd0; tbl_data = 16'h0009;
    stepsel(3'd0, 3'd0);
    tbl_we = 1'b0;
    check("write_in_run_step", {busy, steps, word}, {1'b1, 8'd1, 16'h0049});
    abort = 1'b1; tick(); abort = 1'b0;
    go(3'd3);
    stepsel(3'd0, 3'd0);
    check("old_entry_used", {busy, trapped, steps, word}, {1'b1, 1'b0, 8'd1, 16'h0049});
    abort = 1'b1; tick(); abort = 1'b0;

    // Asynchronous reset mid-search.
    go(3'd3);
    for (int i = 0; i < 3; i++) stepsel(vec[i].sw, vec[i].sl);
    check("pre_reset_step3", {busy, steps, word}, {1'b1, 8'd3, 16'h0063});
    #2 rst = 1'b1;
    #1 check("async_reset", {busy, found, trapped, timeout, steps, word}, '0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("no_pulse_after_reset", {busy, found, trapped, timeout, steps, word}, '0);
    for (int s = 0; s < NW; s++) begin
      go(3'(s));
      check($sformatf("cleared_entry%0d", s), {busy, trapped, word}, {1'b0, 1'b1, 16'h0000});
    end

    // Step bound: a=0x0008 at 0, aa=0x0040 at 1.
    pulse_reset();
    wr(3'd0, 16'h0008);
    wr(3'd1, 16'h0040);
    go(3'd1);
    stepsel(3'd0, 3'd0);
    check("aa_a_step1", {busy3, steps3, word3}, {1'b1, 2'd1, 16'h0008});
    stepsel(3'd0, 3'd0);
    check("aa_a_finds", {busy3, found3, trapped3, timeout3, steps3}, {1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
    abort = 1'b1; tick(); abort = 1'b0;
    go(3'd0);
    stepsel(3'd1, 3'd0);
    check("loop_step1", {busy3, steps3, word3}, {1'b1, 2'd1, 16'h0008});
    stepsel(3'd1, 3'd0);
    check("loop_step2", {busy3, trapped3, steps3}, {1'b1, 1'b0, 2'd2});
    stepsel(3'd1, 3'd0);
    check("timeout_ms3", {busy3, found3, trapped3, timeout3, steps3}, {1'b0, 1'b0, 1'b1, 1'b1, 2'd2});
    check("no_timeout_default", {busy, trapped, timeout, steps}, {1'b1, 1'b0, 1'b0, 8'd3});
    for (int i = 0; i < 251; i++) stepsel(3'd1, 3'd0);
    check("default_step254", {busy, trapped, timeout, steps}, {1'b1, 1'b0, 1'b0, 8'd254});
    stepsel(3'd1, 3'd0);
    check("timeout_default", {busy, found, trapped, timeout, steps}, {1'b0, 1'b0, 1'b1, 1'b1, 8'd254});

    // Randomized run against the model.
    pulse_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      abort  = ($urandom_range(0, 11) == 0);
      start  = ($urandom_range(0, 3) == 0);
      tbl_we = ($urandom_range(0, 2) == 0);
      tbl_addr = 3'($urandom_range(0, NW-1));
      wr_w = rand_word();
      tbl_data = enc(wr_w);
      sel_word = 3'($urandom_range(0, NW-1));
      sel_len  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
      model_cycle(255);
      tick();
      check($sformatf("random_cycle%0d", n), {busy, found, trapped, timeout, steps, word},
            {mbusy, mfound, mtrap, mto, 8'(msteps), enc(mw)});
    end
    abort = 1'b0; start = 1'b0; tbl_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
